// File: rtl/pipeline_pkg.sv
// Shared pipeline constants for the 5-stage RV32I core: datapath width,
// bubble encodings of the control bundles and the control-bit indices.
package pipeline_pkg;
  localparam int XLEN = 32;

  localparam logic [1:0] WB_NOP  = 2'b00;
  localparam logic [1:0] MEM_NOP = 2'b00;
  localparam logic [3:0] EX_NOP  = 4'b0000;

  localparam int WB_REGWRITE = 1;
  localparam int MEM_MEMREAD = 1;
endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: the load in ID/EX writes a register that
// the instruction in IF/ID actually reads. x0 never creates a dependency.
module hazard_detect (
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  output logic       load_use_o
);
  logic rs1_hit, rs2_hit;

  assign rs1_hit    = id_uses_rs1_i && (ex_rd_i == id_rs1_i);
  assign rs2_hit    = id_uses_rs2_i && (ex_rd_i == id_rs2_i);
  assign load_use_o = ex_memread_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush that
// survives a global hold, and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int XLEN  = pipeline_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_rs1_addr,
  input  logic [4:0]       IF_ID_rs2_addr,
  input  logic [4:0]       IF_ID_rd,
  input  logic             IF_ID_uses_rs1,
  input  logic             IF_ID_uses_rs2,
  input  logic [XLEN-1:0]  IF_ID_pc,
  input  logic [XLEN-1:0]  IF_ID_imm,
  input  logic [XLEN-1:0]  IF_ID_rs1_data,
  input  logic [XLEN-1:0]  IF_ID_rs2_data,
  input  logic [1:0]       IF_ID_wb,
  input  logic [1:0]       IF_ID_mem,
  input  logic [3:0]       IF_ID_ex,
  input  logic             branch_taken,
  input  logic             hold,
  output logic [4:0]       ID_EX_rs1_addr,
  output logic [4:0]       ID_EX_rs2_addr,
  output logic [4:0]       ID_EX_rd,
  output logic [XLEN-1:0]  ID_EX_pc,
  output logic [XLEN-1:0]  ID_EX_imm,
  output logic [XLEN-1:0]  ID_EX_rs1_data,
  output logic [XLEN-1:0]  ID_EX_rs2_data,
  output logic [1:0]       ID_EX_wb,
  output logic [1:0]       ID_EX_mem,
  output logic [3:0]       ID_EX_ex,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import pipeline_pkg::*;

  logic [4:0]       rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_q, rd_d;
  logic [XLEN-1:0]  pc_q, pc_d, imm_q, imm_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [1:0]       wb_q, wb_d, mem_q, mem_d;
  logic [3:0]       ex_q, ex_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             load_use, flush_eff;

  hazard_detect u_hazard (
    .ex_memread_i  (mem_q[MEM_MEMREAD]),
    .ex_rd_i       (rd_q),
    .id_rs1_i      (IF_ID_rs1_addr),
    .id_rs2_i      (IF_ID_rs2_addr),
    .id_uses_rs1_i (IF_ID_uses_rs1),
    .id_uses_rs2_i (IF_ID_uses_rs2),
    .load_use_o    (load_use)
  );

  // A branch seen during hold is parked in flush_pend until the first free edge.
  assign flush_eff   = branch_taken | flush_pend_q;
  assign pc_write    = !hold && !(load_use && !flush_eff);
  assign if_id_write = pc_write;
  assign if_id_flush = flush_eff && !hold;

  always_comb begin
    rs1_addr_d   = rs1_addr_q;
    rs2_addr_d   = rs2_addr_q;
    rd_d         = rd_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    wb_d         = wb_q;
    mem_d        = mem_q;
    ex_d         = ex_q;
    flush_pend_d = flush_pend_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (hold) begin
      flush_pend_d = flush_pend_q | branch_taken;
    end else if (flush_eff || load_use) begin
      rs1_addr_d = 5'd0;
      rs2_addr_d = 5'd0;
      rd_d       = 5'd0;
      pc_d       = '0;
      imm_d      = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      wb_d       = WB_NOP;
      mem_d      = MEM_NOP;
      ex_d       = EX_NOP;
      // The flush wins: a coincident stalled instruction is wrong-path anyway.
      if (flush_eff) begin
        flush_pend_d = 1'b0;
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else begin
      rs1_addr_d = IF_ID_rs1_addr;
      rs2_addr_d = IF_ID_rs2_addr;
      rd_d       = IF_ID_rd;
      pc_d       = IF_ID_pc;
      imm_d      = IF_ID_imm;
      rs1_data_d = IF_ID_rs1_data;
      rs2_data_d = IF_ID_rs2_data;
      wb_d       = IF_ID_wb;
      mem_d      = IF_ID_mem;
      ex_d       = IF_ID_ex;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_addr_q   <= 5'd0;
      rs2_addr_q   <= 5'd0;
      rd_q         <= 5'd0;
      pc_q         <= '0;
      imm_q        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      wb_q         <= WB_NOP;
      mem_q        <= MEM_NOP;
      ex_q         <= EX_NOP;
      flush_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      rs1_addr_q   <= rs1_addr_d;
      rs2_addr_q   <= rs2_addr_d;
      rd_q         <= rd_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      wb_q         <= wb_d;
      mem_q        <= mem_d;
      ex_q         <= ex_d;
      flush_pend_q <= flush_pend_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ID_EX_rs1_addr = rs1_addr_q;
  assign ID_EX_rs2_addr = rs2_addr_q;
  assign ID_EX_rd       = rd_q;
  assign ID_EX_pc       = pc_q;
  assign ID_EX_imm      = imm_q;
  assign ID_EX_rs1_data = rs1_data_q;
  assign ID_EX_rs2_data = rs2_data_q;
  assign ID_EX_wb       = wb_q;
  assign ID_EX_mem      = mem_q;
  assign ID_EX_ex       = ex_q;
  assign stall_cnt      = stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected ID/EX contents are queued as each
// step is driven and popped after the capturing edge.
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       IF_ID_rs1_addr, IF_ID_rs2_addr, IF_ID_rd;
  logic             IF_ID_uses_rs1, IF_ID_uses_rs2;
  logic [XLEN-1:0]  IF_ID_pc, IF_ID_imm, IF_ID_rs1_data, IF_ID_rs2_data;
  logic [1:0]       IF_ID_wb, IF_ID_mem;
  logic [3:0]       IF_ID_ex;
  logic             branch_taken, hold;
  logic [4:0]       ID_EX_rs1_addr, ID_EX_rs2_addr, ID_EX_rd;
  logic [XLEN-1:0]  ID_EX_pc, ID_EX_imm, ID_EX_rs1_data, ID_EX_rs2_data;
  logic [1:0]       ID_EX_wb, ID_EX_mem;
  logic [3:0]       ID_EX_ex;
  logic             pc_write, if_id_write, if_id_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [1:0]      wb;
    logic [1:0]      mem;
    logic [3:0]      ex;
    logic [XLEN-1:0] pc;
  } exp_t;
  exp_t exp_q[$];

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs1_addr(IF_ID_rs1_addr), .IF_ID_rs2_addr(IF_ID_rs2_addr), .IF_ID_rd(IF_ID_rd),
    .IF_ID_uses_rs1(IF_ID_uses_rs1), .IF_ID_uses_rs2(IF_ID_uses_rs2),
    .IF_ID_pc(IF_ID_pc), .IF_ID_imm(IF_ID_imm),
    .IF_ID_rs1_data(IF_ID_rs1_data), .IF_ID_rs2_data(IF_ID_rs2_data),
    .IF_ID_wb(IF_ID_wb), .IF_ID_mem(IF_ID_mem), .IF_ID_ex(IF_ID_ex),
    .branch_taken(branch_taken), .hold(hold),
    .ID_EX_rs1_addr(ID_EX_rs1_addr), .ID_EX_rs2_addr(ID_EX_rs2_addr), .ID_EX_rd(ID_EX_rd),
    .ID_EX_pc(ID_EX_pc), .ID_EX_imm(ID_EX_imm),
    .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
    .ID_EX_wb(ID_EX_wb), .ID_EX_mem(ID_EX_mem), .ID_EX_ex(ID_EX_ex),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [1:0] wb,
                     input logic [1:0] mem, input logic [3:0] ex, input logic [XLEN-1:0] pc);
    IF_ID_rd = rd; IF_ID_rs1_addr = rs1; IF_ID_rs2_addr = rs2;
    IF_ID_uses_rs1 = u1; IF_ID_uses_rs2 = u2;
    IF_ID_wb = wb; IF_ID_mem = mem; IF_ID_ex = ex; IF_ID_pc = pc;
    IF_ID_imm = pc ^ 32'h5a5a_0000;
    IF_ID_rs1_data = pc + 32'd1; IF_ID_rs2_data = pc + 32'd2;
  endtask

  task automatic comb(input string tag, input logic pw, input logic fl);
    #1;
    chk({tag, ".pc_write"}, 32'(pc_write), 32'(pw));
    chk({tag, ".if_id_write"}, 32'(if_id_write), 32'(pw));
    chk({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(fl));
  endtask

  task automatic expect_id(input logic [4:0] rd, input logic [4:0] rs1, input logic [1:0] wb,
                           input logic [1:0] mem, input logic [3:0] ex, input logic [XLEN-1:0] pc);
    exp_t e;
    e.rd = rd; e.rs1 = rs1; e.wb = wb; e.mem = mem; e.ex = ex; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".rd"},  32'(ID_EX_rd), 32'(e.rd));
      chk({tag, ".rs1"}, 32'(ID_EX_rs1_addr), 32'(e.rs1));
      chk({tag, ".wb"},  32'(ID_EX_wb), 32'(e.wb));
      chk({tag, ".mem"}, 32'(ID_EX_mem), 32'(e.mem));
      chk({tag, ".ex"},  32'(ID_EX_ex), 32'(e.ex));
      chk({tag, ".pc"},  ID_EX_pc, e.pc);
    end
  endtask

  task automatic cnts(input string tag, input int st, input int fl);
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(st));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(fl));
  endtask

  initial begin
    rst_n = 1'b0; branch_taken = 1'b0; hold = 1'b0;
    put(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 32'h0);
    #2;
    chk("reset.rd", 32'(ID_EX_rd), 32'd0);
    chk("reset.wb", 32'(ID_EX_wb), 32'd0);
    chk("reset.mem", 32'(ID_EX_mem), 32'd0);
    cnts("reset", 0, 0);
    comb("reset", 1'b1, 1'b0);
    rst_n = 1'b1;

    // straight-line capture
    put(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 2'b10, 2'b00, 4'b0011, 32'h100);
    comb("straight", 1'b1, 1'b0);
    expect_id(5'd5, 5'd1, 2'b10, 2'b00, 4'b0011, 32'h100);
    tick("straight");
    chk("straight.imm", ID_EX_imm, 32'h5a5a_0100);
    chk("straight.rs2_data", ID_EX_rs2_data, 32'h102);
    cnts("straight", 0, 0);

    // lw x7 followed by add x8,x7,x1: one bubble, then the add
    put(5'd7, 5'd2, 5'd0, 1'b1, 1'b0, 2'b11, 2'b10, 4'b0001, 32'h104);
    comb("lw7", 1'b1, 1'b0);
    expect_id(5'd7, 5'd2, 2'b11, 2'b10, 4'b0001, 32'h104);
    tick("lw7");
    put(5'd8, 5'd7, 5'd1, 1'b1, 1'b1, 2'b10, 2'b00, 4'b0000, 32'h108);
    comb("loaduse", 1'b0, 1'b0);
    expect_id(5'd0, 5'd0, 2'b00, 2'b00, 4'b0000, 32'h0);
    tick("loaduse");
    cnts("loaduse", 1, 0);
    comb("loaduse_next", 1'b1, 1'b0);
    expect_id(5'd8, 5'd7, 2'b10, 2'b00, 4'b0000, 32'h108);
    tick("loaduse_next");
    cnts("loaduse_next", 1, 0);

    // lw x0 followed by a reader of x0: no stall
    put(5'd0, 5'd8, 5'd0, 1'b1, 1'b0, 2'b11, 2'b10, 4'b0001, 32'h10c);
    comb("lwx0", 1'b1, 1'b0);
    expect_id(5'd0, 5'd8, 2'b11, 2'b10, 4'b0001, 32'h10c);
    tick("lwx0");
    put(5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 2'b10, 2'b00, 4'b0000, 32'h110);
    comb("x0reader", 1'b1, 1'b0);
    expect_id(5'd9, 5'd0, 2'b10, 2'b00, 4'b0000, 32'h110);
    tick("x0reader");

    // lw x3 followed by lui whose unused address fields match: no stall
    put(5'd3, 5'd9, 5'd0, 1'b1, 1'b0, 2'b11, 2'b10, 4'b0001, 32'h114);
    comb("lw3", 1'b1, 1'b0);
    expect_id(5'd3, 5'd9, 2'b11, 2'b10, 4'b0001, 32'h114);
    tick("lw3");
    put(5'd4, 5'd3, 5'd3, 1'b0, 1'b0, 2'b10, 2'b00, 4'b0001, 32'h118);
    comb("lui", 1'b1, 1'b0);
    expect_id(5'd4, 5'd3, 2'b10, 2'b00, 4'b0001, 32'h118);
    tick("lui");
    cnts("lui", 1, 0);

    // load-use and branch in the same cycle: flush wins
    put(5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 2'b11, 2'b10, 4'b0001, 32'h11c);
    comb("lw6", 1'b1, 1'b0);
    expect_id(5'd6, 5'd0, 2'b11, 2'b10, 4'b0001, 32'h11c);
    tick("lw6");
    put(5'd10, 5'd1, 5'd6, 1'b1, 1'b1, 2'b10, 2'b00, 4'b0000, 32'h120);
    branch_taken = 1'b1;
    comb("flushstall", 1'b1, 1'b1);
    expect_id(5'd0, 5'd0, 2'b00, 2'b00, 4'b0000, 32'h0);
    tick("flushstall");
    cnts("flushstall", 1, 1);
    branch_taken = 1'b0;
    comb("postflush", 1'b1, 1'b0);
    expect_id(5'd10, 5'd1, 2'b10, 2'b00, 4'b0000, 32'h120);
    tick("postflush");

    // branch during a 3-cycle hold: applied once on the first free edge
    put(5'd11, 5'd2, 5'd3, 1'b1, 1'b1, 2'b10, 2'b00, 4'b0010, 32'h124);
    hold = 1'b1; branch_taken = 1'b1;
    comb("hold1", 1'b0, 1'b0);
    expect_id(5'd10, 5'd1, 2'b10, 2'b00, 4'b0000, 32'h120);
    tick("hold1");
    branch_taken = 1'b0;
    comb("hold2", 1'b0, 1'b0);
    expect_id(5'd10, 5'd1, 2'b10, 2'b00, 4'b0000, 32'h120);
    tick("hold2");
    branch_taken = 1'b1;
    comb("hold3", 1'b0, 1'b0);
    expect_id(5'd10, 5'd1, 2'b10, 2'b00, 4'b0000, 32'h120);
    tick("hold3");
    cnts("hold3", 1, 1);
    hold = 1'b0; branch_taken = 1'b0;
    comb("unhold", 1'b1, 1'b1);
    expect_id(5'd0, 5'd0, 2'b00, 2'b00, 4'b0000, 32'h0);
    tick("unhold");
    cnts("unhold", 1, 2);
    comb("afterhold", 1'b1, 1'b0);
    expect_id(5'd11, 5'd2, 2'b10, 2'b00, 4'b0010, 32'h124);
    tick("afterhold");
    cnts("afterhold", 1, 2);

    // park a flush, then reset asynchronously mid-cycle
    hold = 1'b1; branch_taken = 1'b1;
    comb("park", 1'b0, 1'b0);
    expect_id(5'd11, 5'd2, 2'b10, 2'b00, 4'b0010, 32'h124);
    tick("park");
    #2;
    rst_n = 1'b0; hold = 1'b0; branch_taken = 1'b0;
    #1;
    chk("async.rd", 32'(ID_EX_rd), 32'd0);
    chk("async.wb", 32'(ID_EX_wb), 32'd0);
    chk("async.pc", ID_EX_pc, 32'h0);
    cnts("async", 0, 0);
    comb("async", 1'b1, 1'b0);
    #1;
    rst_n = 1'b1;
    put(5'd12, 5'd4, 5'd5, 1'b1, 1'b1, 2'b10, 2'b00, 4'b0100, 32'h128);
    comb("postreset", 1'b1, 1'b0);
    expect_id(5'd12, 5'd4, 2'b10, 2'b00, 4'b0100, 32'h128);
    tick("postreset");
    cnts("postreset", 0, 0);

    chk("scoreboard.drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
